grid_seeder: RTL and testbench

//  Downstream consumer of the 8-bit LFSR (its per-cycle shift_seed output).

---
 rtl/grid_pkg.sv | 18 +
 rtl/grid_seeder.sv | 137 +++++++++++++
 tb/tb_grid_seeder.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/grid_pkg.sv
// Shared constants and types for the board seeder and its neighbours.
package grid_pkg;

    localparam int RW            = 8;               // random sample width (matches the LFSR)
    localparam int ROWS          = 8;               // board rows
    localparam int COLS          = 8;               // board columns, COLS <= RW
    localparam int CELLS         = ROWS * COLS;
    localparam int IDX_W         = $clog2(CELLS);
    localparam int DEF_GUARD     = 1;               // refill instead of committing an empty board
    localparam int DEF_MAX_RETRY = 3;               // refills allowed before an empty board is accepted

    typedef enum logic {IDLE, FILL} seed_state_t;

    typedef enum logic {MODE_ROW, MODE_CELL} seed_mode_t;

    typedef logic [CELLS-1:0] grid_t;

endpackage

// File: rtl/grid_seeder.sv
// Builds a ROWSxCOLS board from successive LFSR samples and commits it atomically.
//
//  state | meaning
//  IDLE  | waiting for start; grid holds the last committed board
//  FILL  | consuming one sample per edge into the shadow board
module grid_seeder
    import grid_pkg::*;
#(
    parameter int GUARD     = DEF_GUARD,
    parameter int MAX_RETRY = DEF_MAX_RETRY
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [RW-1:0]        rnd,
    input  logic                 start,
    input  logic                 mode,
    input  logic [RW-1:0]        density,
    output logic [CELLS-1:0]     grid,
    output logic                 busy,
    output logic                 done,
    output logic                 empty
);

    localparam int RTRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    seed_state_t        r_state;
    seed_state_t        w_next_state;
    seed_mode_t         r_mode;
    logic [RW-1:0]      r_density;
    logic [IDX_W-1:0]   r_idx;
    logic [RTRY_W-1:0]  r_retry;
    grid_t              r_shadow;
    grid_t              r_grid;
    logic               r_done;
    logic               r_empty;

    grid_t              w_candidate;
    logic               w_cell;
    logic               w_last;
    logic               w_refill;
    logic               w_commit;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, plus the shadow board with the current sample merged in so the
    // final write and the commit/refill decision happen on the same edge.
    always_comb begin
        w_next_state = r_state;
        w_candidate  = r_shadow;
        w_cell       = (rnd < r_density);
        w_last       = 1'b0;
        w_refill     = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = FILL;
                end
            end
            FILL: begin
                if (r_mode == MODE_ROW) begin
                    for (int r = 0; r < ROWS; r++) begin
                        if (r_idx == IDX_W'(r)) begin
                            w_candidate[r*COLS +: COLS] = rnd[COLS-1:0];
                        end
                    end
                    w_last = (r_idx == IDX_W'(ROWS - 1));
                end else begin
                    w_candidate[r_idx] = w_cell;
                    w_last = (r_idx == IDX_W'(CELLS - 1));
                end
                if (w_last) begin
                    if ((GUARD != 0) && (w_candidate == '0) && (r_retry < RTRY_W'(MAX_RETRY))) begin
                        w_refill = 1'b1;
                    end else begin
                        w_commit     = 1'b1;
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs decoded from state and registered results.
    always_comb begin
        busy  = (r_state == FILL);
        grid  = r_grid;
        done  = r_done;
        empty = r_empty;
    end

    // Fill datapath: latch settings at start, walk the shadow board, commit or refill.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode    <= MODE_ROW;
            r_density <= '0;
            r_idx     <= '0;
            r_retry   <= '0;
            r_shadow  <= '0;
            r_grid    <= '0;
            r_done    <= 1'b0;
            r_empty   <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (r_state == IDLE) begin
                if (start) begin
                    r_mode    <= seed_mode_t'(mode);
                    r_density <= density;
                    r_idx     <= '0;
                    r_retry   <= '0;
                    r_shadow  <= '0;
                end
            end else if (w_refill) begin
                r_idx    <= '0;
                r_retry  <= r_retry + 1'b1;
                r_shadow <= '0;
            end else if (w_commit) begin
                r_grid   <= w_candidate;
                r_empty  <= (w_candidate == '0);
                r_shadow <= w_candidate;
                r_idx    <= '0;
            end else begin
                r_shadow <= w_candidate;
                r_idx    <= r_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_grid_seeder.sv
// Self-checking bench for grid_seeder: vector table, corner sequences, random fills vs. a model.
module tb_grid_seeder;

    logic        clk;
    logic        reset;
    logic [7:0]  rnd;
    logic        start;
    logic        mode;
    logic [7:0]  density;
    logic [63:0] grid;
    logic        busy;
    logic        done;
    logic        empty;

    int n_checks;
    int n_errors;

    localparam int SEQ_LEN = 320;
    logic [7:0] seq [SEQ_LEN];

    grid_seeder dut (
        .clk     (clk),
        .reset   (reset),
        .rnd     (rnd),
        .start   (start),
        .mode    (mode),
        .density (density),
        .grid    (grid),
        .busy    (busy),
        .done    (done),
        .empty   (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          m;
        logic [7:0]  d;
        int          kind;    // 0 one-hot walk, 1 alternating 00/FF, 2 constant val
        logic [7:0]  val;
        logic [63:0] g;
        int          e;
        bit          emp;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void fill_seq(input int kind, input logic [7:0] val);
        for (int i = 0; i < SEQ_LEN; i++) begin
            case (kind)
                0:       seq[i] = 8'h01 << (i % 8);
                1:       seq[i] = (i % 2 == 1) ? 8'hFF : 8'h00;
                default: seq[i] = val;
            endcase
        end
    endfunction

    // Board from the sample stream: whole-sample rows or threshold cells; an empty board is
    // refilled from the following samples up to three times, then accepted.
    function automatic void model(input bit m, input logic [7:0] d,
                                  output logic [63:0] g, output int edges, output bit emp);
        int pos;
        int n;
        pos = 0;
        n   = m ? 64 : 8;
        g   = '0;
        for (int att = 0; att <= 3; att++) begin
            g = '0;
            for (int i = 0; i < n; i++) begin
                if (m) g[i] = (seq[pos] < d);
                else   g[i*8 +: 8] = seq[pos];
                pos++;
            end
            if (g != 0) break;
        end
        edges = pos;
        emp   = (g == 0);
    endfunction

    // Runs one fill starting at the current cycle; returns in the cycle where done is high.
    task automatic run_fill(input string name, input bit m, input logic [7:0] d,
                            input bit keep_start, input int start_at,
                            input logic [63:0] exp_g, input int exp_e, input bit exp_emp);
        logic [63:0] old;
        int          edges;
        bit          held;
        bit          seen;
        mode    = m;
        density = d;
        start   = 1'b1;
        step();
        if (!keep_start) start = 1'b0;
        check({name, " busy after start"}, 64'(busy), 64'd1);
        check({name, " done clear after start"}, 64'(done), 64'd0);
        mode    = ~m;
        density = ~d;
        old   = grid;
        held  = 1'b1;
        seen  = 1'b0;
        edges = 0;
        for (int k = 0; k < SEQ_LEN; k++) begin
            rnd = seq[k];
            if (!keep_start) start = (k + 1 == start_at);
            step();
            edges = k + 1;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (grid !== old || busy !== 1'b1) held = 1'b0;
        end
        check({name, " done seen"}, 64'(seen), 64'd1);
        check({name, " latency"}, 64'(edges), 64'(exp_e));
        check({name, " grid"}, grid, exp_g);
        check({name, " empty"}, 64'(empty), 64'(exp_emp));
        check({name, " busy at done"}, 64'(busy), 64'd0);
        check({name, " grid held and busy during fill"}, 64'(held), 64'd1);
    endtask

    task automatic idle_after_done(input string name);
        start = 1'b0;
        step();
        check({name, " done one cycle"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [63:0] mg;
        int          me;
        bit          memp;
        bit          m;
        logic [7:0]  d;
        bit          quiet;
        int          gap;

        n_checks = 0;
        n_errors = 0;

        tbl[0] = '{"row onehot",   1'b0, 8'h00, 0, 8'h00, 64'h8040201008040201,   8, 1'b0};
        tbl[1] = '{"cell alt",     1'b1, 8'h80, 1, 8'h00, 64'h5555555555555555,  64, 1'b0};
        tbl[2] = '{"cell dens0",   1'b1, 8'h00, 2, 8'h5A, 64'h0000000000000000, 256, 1'b1};
        tbl[3] = '{"row A5",       1'b0, 8'h00, 2, 8'hA5, 64'hA5A5A5A5A5A5A5A5,   8, 1'b0};
        tbl[4] = '{"cell FF vs FF",1'b1, 8'hFF, 2, 8'hFF, 64'h0000000000000000, 256, 1'b1};
        tbl[5] = '{"cell FE vs FF",1'b1, 8'hFF, 2, 8'hFE, 64'hFFFFFFFFFFFFFFFF,  64, 1'b0};
        tbl[6] = '{"row zeros",    1'b0, 8'h00, 2, 8'h00, 64'h0000000000000000,  32, 1'b1};
        tbl[7] = '{"row 3C",       1'b0, 8'h00, 2, 8'h3C, 64'h3C3C3C3C3C3C3C3C,   8, 1'b0};

        reset   = 1'b1;
        start   = 1'b0;
        mode    = 1'b0;
        density = 8'h00;
        rnd     = 8'h00;
        repeat (3) step();
        check("reset grid",  grid, 64'd0);
        check("reset busy",  64'(busy), 64'd0);
        check("reset done",  64'(done), 64'd0);
        check("reset empty", 64'(empty), 64'd0);
        reset = 1'b0;
        step();

        // Vector table; the one-hot entry also carries an ignored start at E3.
        for (int i = 0; i < 8; i++) begin
            fill_seq(tbl[i].kind, tbl[i].val);
            run_fill(tbl[i].name, tbl[i].m, tbl[i].d, 1'b0, (i == 0) ? 3 : -1,
                     tbl[i].g, tbl[i].e, tbl[i].emp);
            idle_after_done(tbl[i].name);
        end

        // Reset in the middle of a fill.
        fill_seq(0, 8'h00);
        mode  = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            rnd = seq[e-1];
            step();
        end
        reset = 1'b1;
        rnd   = seq[4];
        step();
        check("midreset grid",  grid, 64'd0);
        check("midreset busy",  64'(busy), 64'd0);
        check("midreset done",  64'(done), 64'd0);
        check("midreset empty", 64'(empty), 64'd0);
        reset = 1'b0;
        quiet = 1'b1;
        for (int c = 0; c < 12; c++) begin
            rnd = 8'(c);
            step();
            if (done || busy) quiet = 1'b0;
        end
        check("midreset no done", 64'(quiet), 64'd1);
        fill_seq(0, 8'h00);
        run_fill("after reset", 1'b0, 8'h00, 1'b0, -1, 64'h8040201008040201, 8, 1'b0);
        idle_after_done("after reset");

        // Back-to-back: start held across done starts the next fill on the done cycle.
        fill_seq(2, 8'h11);
        run_fill("b2b first", 1'b0, 8'h00, 1'b1, -1, 64'h1111111111111111, 8, 1'b0);
        fill_seq(2, 8'h22);
        run_fill("b2b second", 1'b0, 8'h00, 1'b0, -1, 64'h2222222222222222, 8, 1'b0);
        idle_after_done("b2b second");

        // Random fills against the model.
        for (int it = 0; it < 24; it++) begin
            m = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       d = 8'h00;
                1:       d = 8'hFF;
                2:       d = 8'($urandom_range(1, 8));
                default: d = 8'($urandom);
            endcase
            if ($urandom_range(0, 2) == 0) begin
                for (int i = 0; i < SEQ_LEN; i++)
                    seq[i] = ($urandom_range(0, 40) == 0) ? 8'($urandom) : 8'h00;
            end else begin
                for (int i = 0; i < SEQ_LEN; i++) seq[i] = 8'($urandom);
            end
            model(m, d, mg, me, memp);
            run_fill("random", m, d, 1'b0, -1, mg, me, memp);
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                idle_after_done("random");
                repeat (gap - 1) step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
